// File: rtl/io_sw_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : io_sw_debounce                                               |
// | Description : Slide-switch input conditioner. Each raw pin is passed       |
// |               through a multi-flop synchroniser and then debounced by its  |
// |               own counter. Produces a stable switch word, registered       |
// |               one-cycle rise/fall pulses, a combined "any change" pulse    |
// |               and sticky per-bit event flags with write-1-to-clear.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   i_clk        in   1      system clock                                    |
// |   i_reset      in   1      asynchronous, active-high reset                 |
// |   i_sw_raw     in   WIDTH  raw asynchronous switch pins                    |
// |   i_event_clr  in   WIDTH  write-1-to-clear mask for o_sw_event            |
// |   o_sw_stable  out  WIDTH  debounced switch level                          |
// |   o_sw_rise    out  WIDTH  1-cycle pulse when o_sw_stable[i] goes 0->1     |
// |   o_sw_fall    out  WIDTH  1-cycle pulse when o_sw_stable[i] goes 1->0     |
// |   o_sw_event   out  WIDTH  sticky flag, set on any debounced change        |
// |   o_sw_any     out  1      1-cycle pulse when any bit changed              |
// +----------------------------------------------------------------------------+
module io_sw_debounce #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned SYNC_STAGES     = 2,       // >= 2
  parameter int unsigned DEBOUNCE_CYCLES = 500000   // >= 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sw_raw,
  input  logic [WIDTH-1:0] i_event_clr,
  output logic [WIDTH-1:0] o_sw_stable,
  output logic [WIDTH-1:0] o_sw_rise,
  output logic [WIDTH-1:0] o_sw_fall,
  output logic [WIDTH-1:0] o_sw_event,
  output logic             o_sw_any
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // Terminal count: the commit happens on the edge where the counter already
  // holds DEBOUNCE_CYCLES-1, so a new level is taken after exactly
  // DEBOUNCE_CYCLES consecutive differing samples.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Synchroniser: stage 0 samples the pins, the last stage is the clean level.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_sw_raw};

  // --------------------------------------------------------------------------
  // Debounce state
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q,   rise_d;
  logic [WIDTH-1:0] fall_q,   fall_d;
  logic [WIDTH-1:0] event_q,  event_d;
  logic             any_q,    any_d;

  logic [WIDTH-1:0] sw_s;     // synchronised pin level
  logic [WIDTH-1:0] differ;   // synchronised level disagrees with stable level
  logic [WIDTH-1:0] commit;   // bit takes its new level on this edge

  assign sw_s   = sync_q[SYNC_STAGES-1];
  assign differ = sw_s ^ stable_q;

  // Per-bit counter: cleared whenever the input agrees with the stable level,
  // so any bounce shorter than the debounce window leaves no trace. The
  // counter is cleared on commit and therefore never exceeds CNT_LAST.
  always_comb begin
    commit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!differ[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]  = '0;
        commit[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // A committing bit always differs from its stable value, so the new level
  // is simply the synchronised level; the direction follows from it.
  assign stable_d = stable_q ^ commit;
  assign rise_d   = commit & sw_s;
  assign fall_d   = commit & ~sw_s;
  assign any_d    = |commit;

  // Set has priority over clear: a change committing on the same edge as a
  // clear request leaves the flag set.
  assign event_d  = (event_q & ~i_event_clr) | commit;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q   <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      event_q  <= '0;
      any_q    <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      event_q  <= event_d;
      any_q    <= any_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Every output comes straight from a flop.
  assign o_sw_stable = stable_q;
  assign o_sw_rise   = rise_q;
  assign o_sw_fall   = fall_q;
  assign o_sw_event  = event_q;
  assign o_sw_any    = any_q;

endmodule
`default_nettype wire

// File: tb/tb_io_sw_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_io_sw_debounce                                            |
// | Description : Self-checking bench for io_sw_debounce with a behavioural    |
// |               reference: a switch bit changes once its last DEBOUNCE       |
// |               synchronised samples all disagree with the current level.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_io_sw_debounce;

  localparam int W  = 32;
  localparam int SS = 2;
  localparam int D  = 4;

  logic         i_clk;
  logic         i_reset;
  logic [W-1:0] i_sw_raw;
  logic [W-1:0] i_event_clr;
  logic [W-1:0] o_sw_stable;
  logic [W-1:0] o_sw_rise;
  logic [W-1:0] o_sw_fall;
  logic [W-1:0] o_sw_event;
  logic         o_sw_any;

  io_sw_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_sw_raw   (i_sw_raw),
    .i_event_clr(i_event_clr),
    .o_sw_stable(o_sw_stable),
    .o_sw_rise  (o_sw_rise),
    .o_sw_fall  (o_sw_fall),
    .o_sw_event (o_sw_event),
    .o_sw_any   (o_sw_any)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [W-1:0] m_pipe [$];   // raw samples still travelling through the synchroniser
  logic [W-1:0] m_hist [$];   // most recent synchronised samples, up to D of them
  logic [W-1:0] exp_stable, exp_rise, exp_fall, exp_event;
  logic         exp_any;

  always @(posedge i_clk or posedge i_reset) begin : model
    logic [W-1:0] s;
    logic [W-1:0] flip;
    if (i_reset) begin
      m_pipe.delete();
      for (int k = 0; k < SS; k++) m_pipe.push_back('0);
      m_hist.delete();
      exp_stable = '0;
      exp_rise   = '0;
      exp_fall   = '0;
      exp_event  = '0;
      exp_any    = 1'b0;
    end else begin
      s = m_pipe.pop_front();
      m_pipe.push_back(i_sw_raw);
      m_hist.push_back(s);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      flip = '0;
      if (m_hist.size() == D) begin
        flip = '1;
        for (int k = 0; k < D; k++) flip &= (m_hist[k] ^ exp_stable);
      end
      exp_rise   = flip & ~exp_stable;
      exp_fall   = flip & exp_stable;
      exp_event  = (exp_event & ~i_event_clr) | flip;
      exp_any    = |flip;
      exp_stable = exp_stable ^ flip;
    end
  end

  logic [4*W:0] act_b, exp_b;
  assign act_b = {o_sw_stable, o_sw_rise, o_sw_fall, o_sw_event, o_sw_any};
  assign exp_b = {exp_stable, exp_rise, exp_fall, exp_event, exp_any};

  // Stimulus helper: reset with a given pin pattern, returns at the negedge
  // where reset is released (next posedge is edge 1).
  task automatic apply_reset(input logic [W-1:0] raw);
    @(negedge i_clk);
    i_reset     = 1'b1;
    i_sw_raw    = raw;
    i_event_clr = '0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [W-1:0] want;
    @(negedge i_clk);
    i_sw_raw    = '1;
    i_event_clr = '0;
    i_reset     = 1'b1;
    #1;
    n_checks++;
    if (act_b !== '0) begin
      n_fail++;
      $display("FAIL reset_async: outputs %h, expected all zero", act_b);
    end
    repeat (3) begin
      @(negedge i_clk);
      n_checks++;
      if (act_b !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: outputs %h, expected all zero", act_b);
      end
    end
    i_reset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge i_clk);
      want = (n >= 6) ? {W{1'b1}} : {W{1'b0}};
      n_checks++;
      if (o_sw_stable !== want) begin
        n_fail++;
        $display("FAIL reset_latency edge %0d: stable %h, expected %h", n, o_sw_stable, want);
      end
      n_checks++;
      if (o_sw_any !== (n == 6)) begin
        n_fail++;
        $display("FAIL reset_any edge %0d: any %b, expected %b", n, o_sw_any, (n == 6));
      end
      n_checks++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL reset_model edge %0d: got %h expected %h", n, act_b, exp_b);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_clean_rise();
    apply_reset('0);
    i_sw_raw[0] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_sw_stable[0] !== (n >= 6) || o_sw_rise[0] !== (n == 6) || o_sw_any !== (n == 6)) begin
        n_fail++;
        $display("FAIL clean_rise edge %0d: stable0 %b rise0 %b any %b, expected %b %b %b",
                 n, o_sw_stable[0], o_sw_rise[0], o_sw_any, (n >= 6), (n == 6), (n == 6));
      end
      n_checks++;
      if (o_sw_event !== ((n >= 6) ? 32'h1 : 32'h0)) begin
        n_fail++;
        $display("FAIL clean_rise_event edge %0d: event %h, expected %h",
                 n, o_sw_event, ((n >= 6) ? 32'h1 : 32'h0));
      end
      n_checks++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL clean_rise_model edge %0d: got %h expected %h", n, act_b, exp_b);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_bounce();
    apply_reset('0);
    i_sw_raw[3] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_sw_stable[3] !== 1'b0 || o_sw_rise[3] !== 1'b0 || o_sw_event[3] !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_reject edge %0d: stable3 %b rise3 %b event3 %b, expected 0 0 0",
                 n, o_sw_stable[3], o_sw_rise[3], o_sw_event[3]);
      end
      n_checks++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL bounce_model edge %0d: got %h expected %h", n, act_b, exp_b);
      end
      if (n == 3) i_sw_raw[3] = 1'b0;
    end
    i_sw_raw[3] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_sw_stable[3] !== (n >= 6) || o_sw_rise[3] !== (n == 6)) begin
        n_fail++;
        $display("FAIL bounce_commit edge %0d: stable3 %b rise3 %b, expected %b %b",
                 n, o_sw_stable[3], o_sw_rise[3], (n >= 6), (n == 6));
      end
      n_checks++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL bounce_commit_model edge %0d: got %h expected %h", n, act_b, exp_b);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_clear_vs_set();
    apply_reset('0);
    i_sw_raw[5] = 1'b1;
    repeat (7) @(negedge i_clk);
    n_checks++;
    if (o_sw_event !== 32'h20) begin
      n_fail++;
      $display("FAIL clear_setup: event %h, expected 00000020", o_sw_event);
    end
    // Clear bit 5, plus an unset bit which must stay clear.
    i_event_clr = 32'h0000_0220;
    @(negedge i_clk);
    i_event_clr = '0;
    n_checks++;
    if (o_sw_event !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_event: event %h, expected 00000000", o_sw_event);
    end
    n_checks++;
    if (act_b !== exp_b) begin
      n_fail++;
      $display("FAIL clear_model: got %h expected %h", act_b, exp_b);
    end
    i_sw_raw[5] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge i_clk);
      if (n == 6) begin
        n_checks++;
        if (o_sw_fall[5] !== 1'b1 || o_sw_event[5] !== 1'b1) begin
          n_fail++;
          $display("FAIL set_wins: fall5 %b event5 %b, expected 1 1", o_sw_fall[5], o_sw_event[5]);
        end
      end
      if (n == 8) begin
        n_checks++;
        if (o_sw_event !== 32'h20) begin
          n_fail++;
          $display("FAIL set_sticky: event %h, expected 00000020", o_sw_event);
        end
      end
      n_checks++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL set_wins_model edge %0d: got %h expected %h", n, act_b, exp_b);
      end
      i_event_clr = (n == 5) ? 32'h20 : 32'h0;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_simul_fall();
    int any_pulses;
    apply_reset('1);
    repeat (7) @(negedge i_clk);
    i_event_clr = '1;
    @(negedge i_clk);
    i_event_clr = '0;
    i_sw_raw    = '0;
    any_pulses  = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge i_clk);
      if (o_sw_any === 1'b1) any_pulses++;
      n_checks++;
      if (o_sw_fall !== ((n == 6) ? 32'hFFFF_FFFF : 32'h0) || o_sw_rise !== 32'h0) begin
        n_fail++;
        $display("FAIL simul_fall edge %0d: fall %h rise %h", n, o_sw_fall, o_sw_rise);
      end
      n_checks++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL simul_fall_model edge %0d: got %h expected %h", n, act_b, exp_b);
      end
    end
    n_checks++;
    if (any_pulses != 1) begin
      n_fail++;
      $display("FAIL simul_any_count: %0d cycles of o_sw_any, expected 1", any_pulses);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    apply_reset('0);
    i_sw_raw[7] = 1'b1;
    repeat (4) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    n_checks++;
    if (act_b !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: outputs %h, expected all zero", act_b);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_sw_stable[7] !== (n >= 6)) begin
        n_fail++;
        $display("FAIL reset_mid edge %0d: stable7 %b, expected %b", n, o_sw_stable[7], (n >= 6));
      end
      n_checks++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL reset_mid_model edge %0d: got %h expected %h", n, act_b, exp_b);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Random pins with alternating noisy and quiet phases, random clears.
  task automatic test_random();
    logic [W-1:0] tgl;
    int           odds;
    apply_reset(W'($urandom));
    for (int n = 0; n < 600; n++) begin
      @(negedge i_clk);
      n_checks++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL random_model cyc %0d: got %h expected %h", n, act_b, exp_b);
      end
      n_checks++;
      if ((o_sw_rise & o_sw_fall) !== '0) begin
        n_fail++;
        $display("FAIL random_rise_fall cyc %0d: rise %h fall %h overlap", n, o_sw_rise, o_sw_fall);
      end
      odds = ((n / 24) % 2 == 0) ? 2 : 40;
      tgl  = '0;
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(odds - 1) == 0) tgl[b] = 1'b1;
      end
      i_sw_raw    = i_sw_raw ^ tgl;
      i_event_clr = W'($urandom) & W'($urandom) & W'($urandom);
    end
    i_event_clr = '0;
  endtask

  // --------------------------------------------------------------------------
  initial begin
    i_reset     = 1'b1;
    i_sw_raw    = '0;
    i_event_clr = '0;
    test_reset();
    test_clean_rise();
    test_bounce();
    test_clear_vs_set();
    test_simul_fall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
